// File: rtl/soc_mbox_target.sv
// CPU mailbox into the camera/ISP datapath: 4-word SOC bus window over a TX and an RX FIFO.
// Optional SOC_MBOX_IRQ_EN adds the irq output and the CTRL[5:4] interrupt enables.

package soc_pkg;
  typedef logic [31:2] soc_addr_t;
  typedef logic [3:0]  soc_we_t;
  typedef logic [31:0] soc_data_t;
endpackage

// state   | meaning
// ST_IDLE | ready to accept a bus request; side effects commit at this edge
// ST_RESP | completion (bus_rdy/bus_rdata) on the bus; request inputs ignored
module soc_mbox_target
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        arst_n,
  input  soc_addr_t   bus_addr,
  input  logic        bus_re,
  input  soc_we_t     bus_we,
  input  soc_data_t   bus_wdata,
  output soc_data_t   bus_rdata,
  output logic        bus_rdy,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef SOC_MBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e state_q, state_d;

  logic        sel, is_wr, is_rd, req, accept;
  logic [1:0]  idx;
  logic [31:0] be_mask, wdata_m;
  logic        wr_data, rd_data, wr_stat, wr_ctrl;
  logic        tx_flush, rx_flush;

  logic [31:0]   tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LW-1:0] tx_level_q, tx_level_d;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  logic [31:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0] rx_level_q, rx_level_d;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  logic        tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic        bus_rdy_q, bus_rdy_d;
  logic [31:0] bus_rdata_q, bus_rdata_d;
  logic [31:0] status_rd, ctrl_rd, rd_val;

  // ---------------- request decode ----------------
  assign sel     = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign idx     = bus_addr[3:2];
  assign is_wr   = |bus_we;
  assign is_rd   = bus_re & ~is_wr;
  assign req     = sel & (bus_re | is_wr);
  assign be_mask = {{8{bus_we[3]}}, {8{bus_we[2]}}, {8{bus_we[1]}}, {8{bus_we[0]}}};
  assign wdata_m = bus_wdata & be_mask;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == ST_IDLE) & req;
  end

  assign wr_data  = accept & is_wr & (idx == 2'd0);
  assign rd_data  = accept & is_rd & (idx == 2'd0);
  assign wr_stat  = accept & is_wr & (idx == 2'd1);
  assign wr_ctrl  = accept & is_wr & (idx == 2'd2);
  assign tx_flush = wr_ctrl & wdata_m[0];
  assign rx_flush = wr_ctrl & wdata_m[1];

  // ---------------- TX FIFO (bus -> stream) ----------------
  assign tx_full  = (tx_level_q == FULL_LV);
  assign tx_empty = (tx_level_q == '0);
  assign tx_pop   = ~tx_empty & tx_ready;
  assign tx_push  = wr_data & ~tx_full & ~tx_flush;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem_q[tx_rptr_q];

  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    if (tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wdata_m;
  end

  // ---------------- RX FIFO (stream -> bus) ----------------
  assign rx_full  = (rx_level_q == FULL_LV);
  assign rx_empty = (rx_level_q == '0);
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & ~rx_full & ~rx_flush;
  assign rx_pop   = rd_data & ~rx_empty;

  always_comb begin
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  // ---------------- sticky error bits ----------------
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (wr_stat & wdata_m[4]) tx_ovf_d = 1'b0;
    if (wr_stat & wdata_m[5]) rx_udf_d = 1'b0;
    // a flush in the same cycle swallows the push without flagging overflow
    if (wr_data & tx_full & ~tx_flush) tx_ovf_d = 1'b1;
    if (rd_data & rx_empty) rx_udf_d = 1'b1;
  end

  // ---------------- optional interrupt ----------------
`ifdef SOC_MBOX_IRQ_EN
  logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;

  always_comb begin
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    if (wr_ctrl) begin
      rx_ie_d = wdata_m[4];
      tx_ie_d = wdata_m[5];
    end
    irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | tx_ovf_q | rx_udf_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rx_ie_q <= rx_ie_d;
      tx_ie_q <= tx_ie_d;
      irq_q   <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {26'd0, tx_ie_q, rx_ie_q, 4'd0};
`else
  assign ctrl_rd = '0;
`endif

  // ---------------- read mux and completion ----------------
  assign status_rd = {8'd0, 8'(rx_level_q), 8'(tx_level_q), 2'd0,
                      rx_udf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_val = '0;
    case (idx)
      2'd0:    rd_val = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
      2'd1:    rd_val = status_rd;
      2'd2:    rd_val = ctrl_rd;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    bus_rdy_d   = accept;
    bus_rdata_d = (accept & is_rd) ? rd_val : '0;
  end

  assign bus_rdy   = bus_rdy_q;
  assign bus_rdata = bus_rdata_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_level_q  <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_level_q  <= '0;
      tx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
      bus_rdy_q   <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_level_q  <= tx_level_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_level_q  <= rx_level_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_udf_q    <= rx_udf_d;
      bus_rdy_q   <= bus_rdy_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

endmodule

// File: tb/tb_soc_mbox_target.sv
// Scoreboard bench for soc_mbox_target: queue-based mailbox model, directed cases then random traffic.
// Build with SOC_MBOX_IRQ_EN defined to also exercise the interrupt.

module tb_soc_mbox_target;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [27:0] BASE_HI = BASE[31:4];

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:2] bus_addr;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_rdy;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;
`ifdef SOC_MBOX_IRQ_EN
  logic        irq;
`endif

  soc_mbox_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rdy   (bus_rdy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
`ifdef SOC_MBOX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    longint      due;
  } exp_t;

  exp_t        exp_q[$];
  int          rdy_cnt = 0;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (arst_n) begin
      if (bus_rdy) begin
        rdy_cnt++;
        last_rdata = bus_rdata;
        if (exp_q.size() == 0) chk("bus_rdy_spurious", bus_rdy, 0);
        else begin
          e = exp_q.pop_front();
          chk("rdy_timing", 32'(longint'($time) == e.due), 1);
          chk("bus_rdata", bus_rdata, e.data);
        end
      end else begin
        chk("idle_rdata", bus_rdata, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= longint'($time)) begin
          chk("bus_rdy_missing", bus_rdy, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_ovf, m_udf, m_busy;
`ifdef SOC_MBOX_IRQ_EN
  bit          m_rx_ie, m_tx_ie, m_irq;
`endif

  always @(negedge clk) begin : model
    int          txn, rxn;
    bit          wr, acc, rx_push;
    logic [31:0] wd, rd, ctrl_v;
    if (!arst_n) begin
      m_txq.delete();
      m_rxq.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_busy = 0;
`ifdef SOC_MBOX_IRQ_EN
      m_rx_ie = 0;
      m_tx_ie = 0;
      m_irq   = 0;
`endif
    end else begin
      txn = m_txq.size();
      rxn = m_rxq.size();
      chk("tx_valid", tx_valid, 32'(txn != 0));
      if (txn != 0) chk("tx_data", tx_data, m_txq[0]);
      chk("rx_ready", rx_ready, 32'(rxn < DEPTH));
      ctrl_v = '0;
`ifdef SOC_MBOX_IRQ_EN
      chk("irq", irq, 32'(m_irq));
      m_irq  = (m_rx_ie && rxn != 0) || (m_tx_ie && txn == 0) || m_ovf || m_udf;
      ctrl_v = {26'd0, m_tx_ie, m_rx_ie, 4'd0};
`endif
      wr      = (bus_we != 0);
      acc     = (bus_addr[31:4] == BASE_HI) && (bus_re || wr) && !m_busy;
      m_busy  = acc;
      rx_push = (rxn < DEPTH) && rx_valid;
      if (txn != 0 && tx_ready) void'(m_txq.pop_front());
      if (acc) begin
        wd = bus_wdata & {{8{bus_we[3]}}, {8{bus_we[2]}}, {8{bus_we[1]}}, {8{bus_we[0]}}};
        rd = '0;
        case (bus_addr[3:2])
          2'd0: begin
            if (wr) begin
              if (txn == DEPTH) m_ovf = 1;
              else m_txq.push_back(wd);
            end else if (rxn == 0) m_udf = 1;
            else rd = m_rxq.pop_front();
          end
          2'd1: begin
            if (wr) begin
              if (wd[4]) m_ovf = 0;
              if (wd[5]) m_udf = 0;
            end else
              rd = {8'd0, 8'(rxn), 8'(txn), 2'd0, m_udf, m_ovf,
                    rxn == 0, rxn == DEPTH, txn == 0, txn == DEPTH};
          end
          2'd2: begin
            if (wr) begin
              if (wd[0]) m_txq.delete();
              if (wd[1]) begin
                m_rxq.delete();
                rx_push = 0;
              end
`ifdef SOC_MBOX_IRQ_EN
              m_rx_ie = wd[4];
              m_tx_ie = wd[5];
`endif
            end else rd = ctrl_v;
          end
          default: ;
        endcase
        exp_q.push_back('{rd, longint'($time) + 10});
      end
      if (rx_push) m_rxq.push_back(rx_data);
    end
  end

  // ---------------- stimulus ----------------
  bit stream_rand = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (stream_rand) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = $urandom;
    end
  endtask

  // request held through the response cycle, released at T+2
  task automatic op(input logic [27:0] hi, input logic [1:0] idx, input logic re,
                    input logic [3:0] we, input logic [31:0] wd);
    bus_addr  = {hi, idx};
    bus_re    = re;
    bus_we    = we;
    bus_wdata = wd;
    tick();
    tick();
    bus_re = 1'b0;
    bus_we = 4'd0;
  endtask

  task automatic clean();
    stream_rand = 0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    op(BASE_HI, 2'd2, 1'b0, 4'hF, 32'h3);
    op(BASE_HI, 2'd1, 1'b0, 4'hF, 32'h30);
  endtask

  task automatic push_rx(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = base + 32'(i);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int          c0;
    logic [1:0]  idx;
    logic [3:0]  we;
    logic [31:0] wd;
    int          kind;
    arst_n    = 1'b0;
    bus_addr  = {BASE_HI, 2'd3};
    bus_re    = 1'b0;
    bus_we    = 4'd0;
    bus_wdata = '0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    #3;
    chk("rst_bus_rdy", bus_rdy, 0);
    chk("rst_bus_rdata", bus_rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
`ifdef SOC_MBOX_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tick();

    // full-word write drained by the consumer
    clean();
    tx_ready = 1'b1;
    op(BASE_HI, 2'd0, 1'b0, 4'hF, 32'hDEAD_BEEF);
    chk("t1_tx_drained", tx_valid, 0);

    // byte-masked write
    tx_ready = 1'b0;
    op(BASE_HI, 2'd0, 1'b0, 4'b0101, 32'h1122_3344);
    chk("t2_tx_valid", tx_valid, 1);
    chk("t2_tx_data", tx_data, 32'h0022_0044);

    // TX overflow and W1C
    clean();
    for (int i = 0; i < DEPTH + 1; i++) op(BASE_HI, 2'd0, 1'b0, 4'hF, 32'h100 + 32'(i));
    op(BASE_HI, 2'd1, 1'b1, 4'd0, '0);
    chk("t3_tx_full", {31'd0, last_rdata[0]}, 1);
    chk("t3_tx_level", {24'd0, last_rdata[15:8]}, DEPTH);
    chk("t3_tx_ovf", {31'd0, last_rdata[4]}, 1);
    op(BASE_HI, 2'd1, 1'b0, 4'hF, 32'h10);
    op(BASE_HI, 2'd1, 1'b1, 4'd0, '0);
    chk("t3_tx_ovf_clr", {31'd0, last_rdata[4]}, 0);

    // RX order and underflow
    clean();
    push_rx(32'hA0, 3);
    for (int i = 0; i < 4; i++) begin
      op(BASE_HI, 2'd0, 1'b1, 4'd0, '0);
      chk("t4_rx_word", last_rdata, (i < 3) ? 32'hA0 + 32'(i) : 32'h0);
    end
    op(BASE_HI, 2'd1, 1'b1, 4'd0, '0);
    chk("t4_rx_level", {24'd0, last_rdata[23:16]}, 0);
    chk("t4_rx_udf", {31'd0, last_rdata[5]}, 1);

    // read held on DATA for 4 cycles: two transactions
    clean();
    push_rx(32'hB0, 3);
    c0 = rdy_cnt;
    bus_addr = {BASE_HI, 2'd0};
    bus_re   = 1'b1;
    repeat (4) tick();
    bus_re = 1'b0;
    chk("t5_rdy_pulses", 32'(rdy_cnt - c0), 2);
    op(BASE_HI, 2'd1, 1'b1, 4'd0, '0);
    chk("t5_rx_level", {24'd0, last_rdata[23:16]}, 1);

`ifdef SOC_MBOX_IRQ_EN
    clean();
    op(BASE_HI, 2'd2, 1'b0, 4'hF, 32'h10);
    chk("irq_idle", irq, 0);
    push_rx(32'hC0, 1);
    tick();
    chk("irq_rx_set", irq, 1);
    op(BASE_HI, 2'd0, 1'b1, 4'd0, '0);
    chk("irq_rx_clr", irq, 0);
    op(BASE_HI, 2'd2, 1'b0, 4'hF, 32'h0);
`endif

    // random traffic against the model
    clean();
    stream_rand = 1;
    for (int n = 0; n < 1500; n++) begin
      idx  = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 2);
      we   = (idx == 2'd0) ? 4'($urandom_range(1, 15)) : 4'hF;
      wd   = $urandom;
      if (idx == 2'd2 && $urandom_range(0, 3) != 0) wd[1:0] = 2'b00;
      if (kind == 0) we = 4'd0;
      op(($urandom_range(0, 9) == 0) ? (BASE_HI ^ 28'h1) : BASE_HI, idx,
         (kind != 1), we, wd);
      if ($urandom_range(0, 2) == 0) tick();
    end

    // reset in the middle of a read
    stream_rand = 0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    tick();
    op(BASE_HI, 2'd0, 1'b0, 4'hF, 32'h1234);
    push_rx(32'hD0, 1);
    bus_addr = {BASE_HI, 2'd0};
    bus_re   = 1'b1;
    tick();
    chk("mid_rdy_before_rst", bus_rdy, 1);
    #1 arst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_bus_rdy", bus_rdy, 0);
    chk("mid_rst_bus_rdata", bus_rdata, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
`ifdef SOC_MBOX_IRQ_EN
    chk("mid_rst_irq", irq, 0);
`endif
    bus_re = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
